// File: rtl/brick_pkg.sv
// Shared definitions for the brick-wall store: state encoding, default wall
// geometry and the width of the remaining-brick counter.
package brick_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILL    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_CLEARED = 2'd3
  } state_e;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 8;
  localparam int BRICKS_W = $clog2(DEF_ROWS * DEF_COLS + 1);

endpackage

// File: rtl/brick_field.sv
// Brick bitmap with hit handshake, remaining-brick counter, cleared flag and
// a registered renderer read port. The wall is refilled one row per cycle.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 2,
  parameter int COL_W = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_level,
  input  logic                               hit_valid,
  input  logic [ROW_W-1:0]                   hit_row,
  input  logic [COL_W-1:0]                   hit_col,
  output logic                               hit_ready,
  output logic                               hit_done,
  output logic                               hit_broke,
  input  logic [ROW_W-1:0]                   rd_row,
  input  logic [COL_W-1:0]                   rd_col,
  output logic                               rd_brick,
  output logic [$clog2(ROWS*COLS+1)-1:0]     bricks_left,
  output logic                               all_bricks_cleared,
  output logic                               busy
);

  localparam int BL_W = $clog2(ROWS * COLS + 1);

  state_e                     state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [ROWS-1:0][COLS-1:0]  bits_q, bits_d;
  logic [BL_W-1:0]            left_q, left_d;
  logic                       done_q, broke_q, rd_q, cleared_q;

  logic hit_in_range;
  logic rd_in_range;
  logic hit_acc;
  logic hit_hit;
  logic last_row;
  logic ready_s;
  logic busy_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a load restarts the fill from any state except FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_level) state_d = ST_FILL;
        else            state_d = ST_EMPTY;
      end
      ST_FILL: begin
        if (last_row) state_d = ST_ACTIVE;
        else          state_d = ST_FILL;
      end
      ST_ACTIVE: begin
        if (load_level)                                          state_d = ST_FILL;
        else if (hit_acc && hit_hit && (left_q == BL_W'(1)))     state_d = ST_CLEARED;
        else                                                     state_d = ST_ACTIVE;
      end
      ST_CLEARED: begin
        if (load_level) state_d = ST_FILL;
        else            state_d = ST_CLEARED;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State-decoded outputs; ready never looks at hit_valid so physics can hold a hit.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_q)
      ST_FILL:   busy_s  = 1'b1;
      ST_ACTIVE: ready_s = !load_level;
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Hit decode: range check guards the bitmap lookup for out-of-range coordinates.
  always_comb begin
    hit_in_range = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
    rd_in_range  = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    hit_acc      = hit_valid && ready_s;
    hit_hit      = hit_in_range && bits_q[hit_row][hit_col];
    last_row     = (int'(row_q) == ROWS - 1);
  end

  // Bitmap, row pointer and counter next-state: row fill or single-bit clear.
  always_comb begin
    bits_d = bits_q;
    left_d = left_q;
    row_d  = row_q;
    case (state_q)
      ST_FILL: begin
        bits_d[row_q] = '1;
        row_d         = row_q + ROW_W'(1);
        if (last_row) left_d = BL_W'(ROWS * COLS);
        else          left_d = left_q;
      end
      ST_ACTIVE: begin
        if (hit_acc && hit_hit) begin
          bits_d[hit_row][hit_col] = 1'b0;
          left_d                   = left_q - BL_W'(1);
        end else begin
          left_d = left_q;
        end
      end
      default: begin
        bits_d = bits_q;
      end
    endcase
    if (load_level && (state_q != ST_FILL)) row_d = '0;
    else                                    row_d = row_d;
  end

  // Datapath registers and registered result/read/cleared outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q    <= '0;
      row_q     <= '0;
      left_q    <= '0;
      done_q    <= 1'b0;
      broke_q   <= 1'b0;
      rd_q      <= 1'b0;
      cleared_q <= 1'b0;
    end else begin
      bits_q    <= bits_d;
      row_q     <= row_d;
      left_q    <= left_d;
      done_q    <= hit_acc;
      broke_q   <= hit_acc && hit_hit;
      rd_q      <= rd_in_range && bits_q[rd_row][rd_col];
      cleared_q <= (state_d == ST_CLEARED);
    end
  end

  assign hit_ready          = ready_s;
  assign busy               = busy_s;
  assign hit_done           = done_q;
  assign hit_broke          = broke_q;
  assign rd_brick           = rd_q;
  assign bricks_left        = left_q;
  assign all_bricks_cleared = cleared_q;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: a 4x8 wall for the main scenarios and a
// 3x8 wall for out-of-range hits and reads.
module tb_brick_field;
  import brick_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main 4x8 instance
  logic                load_level, hit_valid, hit_ready, hit_done, hit_broke;
  logic [1:0]          hit_row, rd_row;
  logic [2:0]          hit_col, rd_col;
  logic                rd_brick, all_bricks_cleared, busy;
  logic [BRICKS_W-1:0] bricks_left;

  // 3x8 instance
  logic       ld3, hv3, hrdy3, hdone3, hbroke3, rd3, clr3, busy3;
  logic [1:0] hr3, rr3;
  logic [2:0] hc3, rc3;
  logic [4:0] left3;

  brick_field #(.ROWS(4), .COLS(8), .ROW_W(2), .COL_W(3)) dut (
    .clk(clk), .rst(rst), .load_level(load_level),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ready(hit_ready), .hit_done(hit_done), .hit_broke(hit_broke),
    .rd_row(rd_row), .rd_col(rd_col), .rd_brick(rd_brick),
    .bricks_left(bricks_left), .all_bricks_cleared(all_bricks_cleared), .busy(busy)
  );

  brick_field #(.ROWS(3), .COLS(8), .ROW_W(2), .COL_W(3)) dut3 (
    .clk(clk), .rst(rst), .load_level(ld3),
    .hit_valid(hv3), .hit_row(hr3), .hit_col(hc3),
    .hit_ready(hrdy3), .hit_done(hdone3), .hit_broke(hbroke3),
    .rd_row(rr3), .rd_col(rc3), .rd_brick(rd3),
    .bricks_left(left3), .all_bricks_cleared(clr3), .busy(busy3)
  );

  int n_vec = 0;
  int n_err = 0;
  bit sb_q[$];
  bit sb3_q[$];
  bit model_bits[4][8];
  int model_left;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result monitor for the 4x8 wall: a done is owed exactly when the queue holds an entry.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      chk("hit_done", int'(hit_done), 1);
      chk("hit_broke", int'(hit_broke), int'(sb_q.pop_front()));
    end else begin
      chk("hit_done_idle", int'(hit_done), 0);
    end
  end

  // Result monitor for the 3x8 wall.
  always @(posedge clk) begin
    #1;
    if (sb3_q.size() > 0) begin
      chk("hit_done3", int'(hdone3), 1);
      chk("hit_broke3", int'(hbroke3), int'(sb3_q.pop_front()));
    end else begin
      chk("hit_done3_idle", int'(hdone3), 0);
    end
  end

  task automatic model_clear();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        model_bits[r][c] = 1'b0;
    model_left = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(hit_ready), 0);
    chk({tag, "_done"}, int'(hit_done), 0);
    chk({tag, "_broke"}, int'(hit_broke), 0);
    chk({tag, "_rd"}, int'(rd_brick), 0);
    chk({tag, "_left"}, int'(bricks_left), 0);
    chk({tag, "_cleared"}, int'(all_bricks_cleared), 0);
  endtask

  // Called at a negedge; pulses load and walks through the 4-cycle fill.
  task automatic load_fill();
    load_level = 1'b1;
    #1 chk("ready_on_load", int'(hit_ready), 0);
    @(negedge clk);
    load_level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_fill", int'(busy), 1);
      chk("ready_fill", int'(hit_ready), 0);
      chk("cleared_fill", int'(all_bricks_cleared), 0);
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        model_bits[r][c] = 1'b1;
    model_left = 32;
    chk("busy_after_fill", int'(busy), 0);
    chk("ready_after_fill", int'(hit_ready), 1);
    chk("left_after_fill", int'(bricks_left), 32);
    chk("cleared_after_fill", int'(all_bricks_cleared), 0);
  endtask

  // Called at a negedge; presents one hit for one cycle.
  task automatic do_hit(input int r, input int c, input bit exp_ready);
    bit b;
    hit_valid = 1'b1;
    hit_row   = 2'(r);
    hit_col   = 3'(c);
    #1 chk("hit_ready", int'(hit_ready), int'(exp_ready));
    @(posedge clk);
    if (exp_ready) begin
      b = model_bits[r][c];
      if (b) begin
        model_bits[r][c] = 1'b0;
        model_left--;
      end
      sb_q.push_back(b);
    end
    @(negedge clk);
    hit_valid = 1'b0;
    chk("bricks_left", int'(bricks_left), model_left);
  endtask

  task automatic rd_chk(input int r, input int c);
    rd_row = 2'(r);
    rd_col = 3'(c);
    @(negedge clk);
    chk("rd_brick", int'(rd_brick), int'(model_bits[r][c]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load_level = 1'b0; hit_valid = 1'b0; hit_row = 2'd0; hit_col = 3'd0;
    rd_row = 2'd0; rd_col = 3'd0;
    ld3 = 1'b0; hv3 = 1'b0; hr3 = 2'd0; hc3 = 3'd0; rr3 = 2'd0; rc3 = 3'd0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // reset then load
    load_fill();
    rd_chk(3, 7);

    // single hit, repeat on the same brick, another brick
    do_hit(1, 5, 1'b1);
    rd_chk(1, 5);
    do_hit(1, 5, 1'b1);
    do_hit(0, 0, 1'b1);

    // load and hit collide: hit held through the refill, accepted once ACTIVE
    hit_valid = 1'b1;
    hit_row   = 2'd2;
    hit_col   = 3'd3;
    load_fill();
    @(posedge clk);
    model_bits[2][3] = 1'b0;
    model_left--;
    sb_q.push_back(1'b1);
    @(negedge clk);
    hit_valid = 1'b0;
    chk("left_after_collision", int'(bricks_left), 31);

    // clear the whole wall back to back
    load_fill();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        do_hit(r, c, 1'b1);
    chk("cleared_set", int'(all_bricks_cleared), 1);
    chk("left_zero", int'(bricks_left), 0);
    chk("ready_cleared", int'(hit_ready), 0);
    do_hit(0, 0, 1'b0);
    rd_chk(3, 7);
    chk("cleared_held", int'(all_bricks_cleared), 1);

    // reset two cycles into a fill
    load_level = 1'b1;
    @(negedge clk);
    load_level = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("midfill");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    do_hit(0, 0, 1'b0);
    rd_chk(0, 0);
    load_fill();
    do_hit(0, 0, 1'b1);

    // 3x8 wall: out-of-range row, in-range hit, out-of-range read
    ld3 = 1'b1;
    @(negedge clk);
    ld3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("busy3_fill", int'(busy3), 1);
      @(negedge clk);
    end
    chk("busy3_done", int'(busy3), 0);
    chk("left3_full", int'(left3), 24);
    hv3 = 1'b1; hr3 = 2'd3; hc3 = 3'd0;
    #1 chk("ready3", int'(hrdy3), 1);
    @(posedge clk);
    sb3_q.push_back(1'b0);
    @(negedge clk);
    hv3 = 1'b0;
    chk("left3_oor", int'(left3), 24);
    hv3 = 1'b1; hr3 = 2'd2; hc3 = 3'd7;
    #1 chk("ready3_b", int'(hrdy3), 1);
    @(posedge clk);
    sb3_q.push_back(1'b1);
    @(negedge clk);
    hv3 = 1'b0;
    chk("left3_hit", int'(left3), 23);
    rr3 = 2'd3; rc3 = 3'd7;
    @(negedge clk);
    chk("rd3_oor", int'(rd3), 0);
    rr3 = 2'd2; rc3 = 3'd6;
    @(negedge clk);
    chk("rd3_set", int'(rd3), 1);
    rr3 = 2'd2; rc3 = 3'd7;
    @(negedge clk);
    chk("rd3_cleared", int'(rd3), 0);

    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    chk("sb3_drain", sb3_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
